mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MUL_DIV_FAST_MUL_EN to produce multiply results from a single-cycle combinational product.
module mul_div_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [5:0]        op,
   input  logic [DATA_W-1:0] operand_a,
   input  logic [DATA_W-1:0] operand_b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam int CNT_W  = $clog2(DATA_W) + 1;
   localparam int PROD_W = 2 * DATA_W;
   localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic                accept, finish;
   logic [DATA_W-1:0]   res_nxt, fin_val;

   logic [2:0]          op_q;
   logic [DATA_W-1:0]   mag_a, mag_b;
   logic                neg;
   logic                spec_hit;
   logic [DATA_W-1:0]   spec_val;
   logic [PROD_W-1:0]   acc;

   logic signed [DATA_W-1:0] sa, sb;
   logic                a_neg, b_neg, a_sgn, b_sgn, neg_d;
   logic                legal, div0, ovf;
   logic [DATA_W-1:0]   mag_a_d, mag_b_d, spec_val_d;

   logic [DATA_W:0]     mul_sum;
   logic [PROD_W-1:0]   mul_nxt, div_nxt;
   logic [DATA_W:0]     div_shift, div_diff;
   logic                div_ge;
   logic [PROD_W-1:0]   prod_src, prod;
   logic [DATA_W-1:0]   quo, rem;

   function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [PROD_W-1:0] neg_p(input logic [PROD_W-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   assign busy   = (state == MUL) || (state == DIV);
   assign done   = (state == FIN);
   assign accept = start && !busy;

   assign sa    = operand_a;
   assign sb    = operand_b;
   assign a_neg = sa < 0;
   assign b_neg = sb < 0;

   // Operand decode at the accepting edge: magnitudes, result sign, early-exit cases
   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      neg_d = 1'b0;
      case (op[2:0])
         3'b001:  begin a_sgn = 1'b1; b_sgn = 1'b1; neg_d = a_neg ^ b_neg; end
         3'b010:  begin a_sgn = 1'b1; neg_d = a_neg; end
         3'b100:  begin a_sgn = 1'b1; b_sgn = 1'b1; neg_d = a_neg ^ b_neg; end
         3'b110:  begin a_sgn = 1'b1; b_sgn = 1'b1; neg_d = a_neg; end
         default: ;
      endcase
   end

   assign mag_a_d = neg_w(operand_a, a_sgn & a_neg);
   assign mag_b_d = neg_w(operand_b, b_sgn & b_neg);

   assign legal = (op[5:3] == 3'b010);
   assign div0  = op[2] && (operand_b == '0);
   assign ovf   = op[2] && !op[0] && (operand_a == MIN_NEG) && (operand_b == '1);

   always_comb begin
      spec_val_d = '0;
      if (!legal)
         spec_val_d = '0;
      else if (div0)
         spec_val_d = op[1] ? operand_a : '1;
      else if (ovf)
         spec_val_d = op[1] ? '0 : MIN_NEG;
   end

   // Iteration step: multiplier shifts out of acc low half, partial product builds in high half
   assign mul_sum   = {1'b0, acc[PROD_W-1:DATA_W]} + (acc[0] ? {1'b0, mag_a} : '0);
   assign mul_nxt   = {mul_sum, acc[DATA_W-1:1]};
   assign div_shift = {acc[PROD_W-1:DATA_W], acc[DATA_W-1]};
   assign div_ge    = div_shift >= {1'b0, mag_b};
   assign div_diff  = div_shift - {1'b0, mag_b};
   assign div_nxt   = div_ge ? {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1}
                             : {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};

`ifdef MUL_DIV_FAST_MUL_EN
   assign prod_src = {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
`else
   assign prod_src = acc;
`endif

   always_comb begin
      prod = neg_p(prod_src, neg);
      quo  = neg_w(acc[DATA_W-1:0], neg);
      rem  = neg_w(acc[PROD_W-1:DATA_W], neg);
      case (op_q)
         3'b000:                 fin_val = prod[DATA_W-1:0];
         3'b001, 3'b010, 3'b011: fin_val = prod[PROD_W-1:DATA_W];
         3'b100, 3'b101:         fin_val = quo;
         default:                fin_val = rem;
      endcase
   end

   always_comb begin
      state_nxt = state;
      finish    = 1'b0;
      res_nxt   = fin_val;
      case (state)
         MUL, DIV: begin
            if (spec_hit) begin
               finish  = 1'b1;
               res_nxt = spec_val;
            end
`ifdef MUL_DIV_FAST_MUL_EN
            else if ((state == MUL) || (cnt == CNT_W'(DATA_W)))
               finish = 1'b1;
`else
            else if (cnt == CNT_W'(DATA_W))
               finish = 1'b1;
`endif
            if (finish)
               state_nxt = FIN;
         end
         default: state_nxt = accept ? (op[2] ? DIV : MUL) : IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         result <= '0;
      end else begin
         state <= state_nxt;
         if (accept)
            cnt <= '0;
         else if (busy)
            cnt <= cnt + 1'b1;
         if (finish)
            result <= res_nxt;
      end
   end

   // Datapath registers carry no reset; they are always loaded at the accepting edge
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q     <= op[2:0];
         mag_a    <= mag_a_d;
         mag_b    <= mag_b_d;
         neg      <= neg_d;
         spec_hit <= !legal || div0 || ovf;
         spec_val <= spec_val_d;
         acc      <= {{DATA_W{1'b0}}, (op[2] ? mag_a_d : mag_b_d)};
      end else if (busy) begin
         acc <= (state == MUL) ? mul_nxt : div_nxt;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected results/latencies queued at issue, checked at done.
module tb_mul_div_unit;

   localparam logic [5:0] OP_MUL    = 6'b010000;
   localparam logic [5:0] OP_MULH   = 6'b010001;
   localparam logic [5:0] OP_MULHSU = 6'b010010;
   localparam logic [5:0] OP_MULHU  = 6'b010011;
   localparam logic [5:0] OP_DIV    = 6'b010100;
   localparam logic [5:0] OP_DIVU   = 6'b010101;
   localparam logic [5:0] OP_REM    = 6'b010110;
   localparam logic [5:0] OP_REMU   = 6'b010111;
`ifdef MUL_DIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        reset, start, busy, done;
   logic [5:0]  op;
   logic [31:0] operand_a, operand_b, result;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   int          lat_q[$];

   always #5 clk = ~clk;

   mul_div_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b),
      .busy(busy), .done(done), .result(result)
   );

   task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      @(posedge clk); #1;
      start = 1'b0; operand_a = $urandom; operand_b = $urandom;
   endtask

   task automatic wait_done(output int lat, output bit busy_ok);
      lat = 0;
      busy_ok = 1'b1;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(posedge clk); #1;
         if (done) lat = k;
         else if (!busy) busy_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; op = '0; operand_a = '0; operand_b = '0;
      #2 reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_mul();
      logic [5:0]  ops[5] = '{OP_MUL, OP_MULHU, OP_MULHSU, OP_MULH, OP_MULHU};
      logic [31:0] as[5]  = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
      logic [31:0] bs[5]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4};
      logic [31:0] es[5]  = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'd2};
      for (int i = 0; i < 5; i++) begin
         int lat, elat; bit bok; logic [31:0] exp;
         exp_q.push_back(es[i]); lat_q.push_back(MUL_LAT);
         issue(ops[i], as[i], bs[i]);
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy_e0[%0d]: got %b expected 1", i, busy); end
         wait_done(lat, bok);
         exp = exp_q.pop_front(); elat = lat_q.pop_front();
         checks++; if (result !== exp) begin errors++; $display("FAIL mul_result[%0d]: got %h expected %h", i, result, exp); end
         checks++; if (lat !== elat) begin errors++; $display("FAIL mul_latency[%0d]: got %0d expected %0d", i, lat, elat); end
         checks++; if (busy !== 1'b0 || !bok) begin errors++; $display("FAIL mul_busy[%0d]: got fin=%b steady=%b expected 0/1", i, busy, bok); end
      end
   endtask

   task automatic test_div();
      logic [5:0]  ops[6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
      logic [31:0] as[6]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd20, 32'd20};
      logic [31:0] bs[6]  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFD};
      logic [31:0] es[6]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFA, 32'd2};
      for (int i = 0; i < 6; i++) begin
         int lat, elat; bit bok; logic [31:0] exp;
         exp_q.push_back(es[i]); lat_q.push_back(33);
         issue(ops[i], as[i], bs[i]);
         wait_done(lat, bok);
         exp = exp_q.pop_front(); elat = lat_q.pop_front();
         checks++; if (result !== exp) begin errors++; $display("FAIL div_result[%0d]: got %h expected %h", i, result, exp); end
         checks++; if (lat !== elat) begin errors++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, lat, elat); end
         checks++; if (busy !== 1'b0 || !bok) begin errors++; $display("FAIL div_busy[%0d]: got fin=%b steady=%b expected 0/1", i, busy, bok); end
      end
   endtask

   task automatic test_boundary();
      logic [5:0]  ops[7] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, 6'b011000, OP_DIV, OP_REM};
      logic [31:0] as[7]  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd3, 32'd9, 32'hFFFFFFF9};
      logic [31:0] bs[7]  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4, 32'd0, 32'd0};
      logic [31:0] es[7]  = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9};
      for (int i = 0; i < 7; i++) begin
         int lat, elat; bit bok; logic [31:0] exp;
         exp_q.push_back(es[i]); lat_q.push_back(1);
         issue(ops[i], as[i], bs[i]);
         wait_done(lat, bok);
         exp = exp_q.pop_front(); elat = lat_q.pop_front();
         checks++; if (result !== exp) begin errors++; $display("FAIL edge_result[%0d]: got %h expected %h", i, result, exp); end
         checks++; if (lat !== elat) begin errors++; $display("FAIL edge_latency[%0d]: got %0d expected %0d", i, lat, elat); end
      end
   endtask

   task automatic test_back_to_back();
      int lat, elat; bit bok; logic [31:0] exp;
      exp_q.push_back(32'd14); lat_q.push_back(28);
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (4) @(posedge clk);
      #1 start = 1'b1; op = OP_MUL; operand_a = 32'd3; operand_b = 32'd4;
      @(posedge clk); #1 start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignored_start_busy: got %b expected 1", busy); end
      wait_done(lat, bok);
      exp = exp_q.pop_front(); elat = lat_q.pop_front();
      checks++; if (result !== exp) begin errors++; $display("FAIL ignored_start_result: got %h expected %h", result, exp); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL ignored_start_latency: got %0d expected %0d", lat, elat); end
      exp_q.push_back(32'd2); lat_q.push_back(33);
      start = 1'b1; op = OP_REMU; operand_a = 32'd100; operand_b = 32'd7;
      @(posedge clk); #1 start = 1'b0;
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL fin_start_accept: got busy=%b done=%b expected 1/0", busy, done); end
      wait_done(lat, bok);
      exp = exp_q.pop_front(); elat = lat_q.pop_front();
      checks++; if (result !== exp) begin errors++; $display("FAIL fin_start_result: got %h expected %h", result, exp); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL fin_start_latency: got %0d expected %0d", lat, elat); end
   endtask

   task automatic test_reset_abort();
      int lat, elat; bit bok; bit seen; logic [31:0] exp;
      issue(OP_DIVU, 32'd1000, 32'd3);
      repeat (10) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL abort_result: got %h expected 0", result); end
      @(posedge clk);
      @(negedge clk) reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", seen); end
      exp_q.push_back(32'd12); lat_q.push_back(MUL_LAT);
      issue(OP_MUL, 32'd3, 32'd4);
      wait_done(lat, bok);
      exp = exp_q.pop_front(); elat = lat_q.pop_front();
      checks++; if (result !== exp) begin errors++; $display("FAIL post_reset_mul: got %h expected %h", result, exp); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, elat); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_boundary();
      test_back_to_back();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
